register_read_mp: RTL and testbench

Multi-lane, back-pressured successor to the single-issue register read stage. It sits between the scheduler and execute and serves `NUM_LANES` independent issue lanes. Each lane:
- drives the physical-register-file read ports;
- merges bypass values from the forwarding unit;
- forces preg 0 to zero;
- registers the completed execute packet behind a 2-entry skid buffer, so execute stalls never lose an operand captured in flight.

---
 rtl/register_read_mp_pkg.sv | 54 +++++
 rtl/register_read_mp_rr_lane.sv | 110 +++++++++++
 rtl/register_read_mp.sv | 58 +++++
 tb/tb_register_read_mp.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_read_mp_pkg.sv
// Shared core types and constants for the multi-lane register read stage.
// Latency: n/a (types, constants and a pure operand-select helper only).
// Backpressure: n/a.
// Contents: NUM_PREGS, XLEN, MAX_ISSUE_LANES, PREG_W, sched_pkt_t, exec_pkt_t,
//           lane_state_e, sel_operand().
package register_read_mp_pkg;

  localparam int NUM_PREGS       = 64;
  localparam int XLEN            = 32;
  localparam int MAX_ISSUE_LANES = 4;
  localparam int PREG_W          = $clog2(NUM_PREGS);

  // Packet handed over by the scheduler on a fire.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [PREG_W-1:0] src1_preg;
    logic [PREG_W-1:0] src2_preg;
    logic [PREG_W-1:0] dst_preg;
    logic [XLEN-1:0]   imm_val;
    logic              instr_valid;
  } sched_pkt_t;

  // Packet presented to execute: scheduler fields plus resolved operands.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [PREG_W-1:0] src1_preg;
    logic [PREG_W-1:0] src2_preg;
    logic [PREG_W-1:0] dst_preg;
    logic [XLEN-1:0]   imm_val;
    logic              instr_valid;
    logic [XLEN-1:0]   src1_val;
    logic [XLEN-1:0]   src2_val;
  } exec_pkt_t;

  // Lane occupancy, encoded as {SKID.valid, OUT.valid}.
  typedef enum logic [1:0] {
    LANE_EMPTY = 2'b00,
    LANE_ONE   = 2'b01,
    LANE_FULL  = 2'b11
  } lane_state_e;

  // preg 0 is hard-wired zero and wins over any bypass hit on it.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [PREG_W-1:0] preg,
    input logic              fwd_hit,
    input logic [XLEN-1:0]   fwd_val,
    input logic [XLEN-1:0]   rf_val
  );
    if (preg == '0)   return '0;
    else if (fwd_hit) return fwd_val;
    else              return rf_val;
  endfunction

endpackage

// File: rtl/register_read_mp_rr_lane.sv
// One issue lane: operand select, then OUT register backed by a SKID register.
// Latency: 1 cycle from accept to exec_valid.
// Backpressure: sched_ready = !SKID.valid straight from state flops, so it never
//   depends combinationally on exec_ready; SKID absorbs the one packet in flight.
// Ports: clk, rst (async active-low), flush, sched_valid/ready/pkt,
//        rf_src*_val, fwd_src*_hit/val, exec_valid/ready/pkt.
module rr_lane
  import register_read_mp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             sched_valid,
  output logic             sched_ready,
  input  sched_pkt_t       sched_pkt,
  input  logic [XLEN-1:0]  rf_src1_val,
  input  logic [XLEN-1:0]  rf_src2_val,
  input  logic             fwd_src1_hit,
  input  logic             fwd_src2_hit,
  input  logic [XLEN-1:0]  fwd_src1_val,
  input  logic [XLEN-1:0]  fwd_src2_val,
  output logic             exec_valid,
  input  logic             exec_ready,
  output exec_pkt_t        exec_pkt
);

  lane_state_e state_q;
  lane_state_e state_nxt;
  exec_pkt_t   out_q;
  exec_pkt_t   skid_q;
  exec_pkt_t   cap_pkt;
  logic        accept;
  logic        load_out;
  logic        load_skid;
  logic        skid_to_out;

  assign sched_ready = (state_q != LANE_FULL);
  assign exec_valid  = (state_q != LANE_EMPTY);
  assign exec_pkt    = out_q;
  assign accept      = sched_valid & sched_ready & ~flush;

  // Packet as it would be captured this cycle.
  always_comb begin
    cap_pkt             = '0;
    cap_pkt.pc          = sched_pkt.pc;
    cap_pkt.src1_preg   = sched_pkt.src1_preg;
    cap_pkt.src2_preg   = sched_pkt.src2_preg;
    cap_pkt.dst_preg    = sched_pkt.dst_preg;
    cap_pkt.imm_val     = sched_pkt.imm_val;
    cap_pkt.instr_valid = sched_pkt.instr_valid;
    cap_pkt.src1_val    = sel_operand(sched_pkt.src1_preg, fwd_src1_hit,
                                      fwd_src1_val, rf_src1_val);
    cap_pkt.src2_val    = sel_operand(sched_pkt.src2_preg, fwd_src2_hit,
                                      fwd_src2_val, rf_src2_val);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LANE_EMPTY;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (flush) begin
      // Flush kills everything held; exec_ready this cycle is ignored.
      state_nxt = LANE_EMPTY;
    end else begin
      case (state_q)
        LANE_EMPTY: begin
          if (accept) begin
            load_out  = 1'b1;
            state_nxt = LANE_ONE;
          end
        end
        LANE_ONE: begin
          if (exec_ready) begin
            if (accept) load_out  = 1'b1;
            else        state_nxt = LANE_EMPTY;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = LANE_FULL;
          end
        end
        LANE_FULL: begin
          // sched_ready is low here, so no accept can coincide with the drain.
          if (exec_ready) begin
            skid_to_out = 1'b1;
            state_nxt   = LANE_ONE;
          end
        end
        default: state_nxt = LANE_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)         out_q <= cap_pkt;
      else if (skid_to_out) out_q <= skid_q;
      if (load_skid)        skid_q <= cap_pkt;
    end
  end

endmodule

// File: rtl/register_read_mp.sv
// Multi-lane register read stage: NUM_LANES independent rr_lane instances.
// Latency: 1 cycle per lane from accept to exec_valid.
// Backpressure: per lane; a stall on one lane never affects another.
// Ports: clk, rst (async active-low), flush, sched_valid/ready/pkt,
//        rf_src*_reg/val, fwd_src*_reg/hit/val, exec_valid/ready/pkt.
module register_read_mp
  import register_read_mp_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_LANES-1:0]            sched_valid,
  output logic [NUM_LANES-1:0]            sched_ready,
  input  sched_pkt_t [NUM_LANES-1:0]      sched_pkt,
  output logic [NUM_LANES-1:0][PREG_W-1:0] rf_src1_reg,
  output logic [NUM_LANES-1:0][PREG_W-1:0] rf_src2_reg,
  input  logic [NUM_LANES-1:0][XLEN-1:0]  rf_src1_val,
  input  logic [NUM_LANES-1:0][XLEN-1:0]  rf_src2_val,
  output logic [NUM_LANES-1:0][PREG_W-1:0] fwd_src1_reg,
  output logic [NUM_LANES-1:0][PREG_W-1:0] fwd_src2_reg,
  input  logic [NUM_LANES-1:0]            fwd_src1_hit,
  input  logic [NUM_LANES-1:0]            fwd_src2_hit,
  input  logic [NUM_LANES-1:0][XLEN-1:0]  fwd_src1_val,
  input  logic [NUM_LANES-1:0][XLEN-1:0]  fwd_src2_val,
  output logic [NUM_LANES-1:0]            exec_valid,
  input  logic [NUM_LANES-1:0]            exec_ready,
  output exec_pkt_t [NUM_LANES-1:0]       exec_pkt
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    // Read/lookup addresses are plain copies, driven whether or not valid.
    assign rf_src1_reg[l]  = sched_pkt[l].src1_preg;
    assign rf_src2_reg[l]  = sched_pkt[l].src2_preg;
    assign fwd_src1_reg[l] = sched_pkt[l].src1_preg;
    assign fwd_src2_reg[l] = sched_pkt[l].src2_preg;

    rr_lane u_lane (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .sched_valid  (sched_valid[l]),
      .sched_ready  (sched_ready[l]),
      .sched_pkt    (sched_pkt[l]),
      .rf_src1_val  (rf_src1_val[l]),
      .rf_src2_val  (rf_src2_val[l]),
      .fwd_src1_hit (fwd_src1_hit[l]),
      .fwd_src2_hit (fwd_src2_hit[l]),
      .fwd_src1_val (fwd_src1_val[l]),
      .fwd_src2_val (fwd_src2_val[l]),
      .exec_valid   (exec_valid[l]),
      .exec_ready   (exec_ready[l]),
      .exec_pkt     (exec_pkt[l])
    );
  end

endmodule

// File: tb/tb_register_read_mp.sv
// Directed bench for register_read_mp: operand-select vector table on lane 0,
// then hand-written skid, flush and async-reset sequences.
module tb_register_read_mp;
  import register_read_mp_pkg::*;

  localparam int NL = 2;

  logic                        clk;
  logic                        rst;
  logic                        flush;
  logic [NL-1:0]               sched_valid;
  logic [NL-1:0]               sched_ready;
  sched_pkt_t [NL-1:0]         sched_pkt;
  logic [NL-1:0][PREG_W-1:0]   rf_src1_reg, rf_src2_reg;
  logic [NL-1:0][XLEN-1:0]     rf_src1_val, rf_src2_val;
  logic [NL-1:0][PREG_W-1:0]   fwd_src1_reg, fwd_src2_reg;
  logic [NL-1:0]               fwd_src1_hit, fwd_src2_hit;
  logic [NL-1:0][XLEN-1:0]     fwd_src1_val, fwd_src2_val;
  logic [NL-1:0]               exec_valid;
  logic [NL-1:0]               exec_ready;
  exec_pkt_t [NL-1:0]          exec_pkt;

  int n_checks = 0;
  int n_fail   = 0;

  register_read_mp #(.NUM_LANES(NL)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .sched_valid  (sched_valid),
    .sched_ready  (sched_ready),
    .sched_pkt    (sched_pkt),
    .rf_src1_reg  (rf_src1_reg),
    .rf_src2_reg  (rf_src2_reg),
    .rf_src1_val  (rf_src1_val),
    .rf_src2_val  (rf_src2_val),
    .fwd_src1_reg (fwd_src1_reg),
    .fwd_src2_reg (fwd_src2_reg),
    .fwd_src1_hit (fwd_src1_hit),
    .fwd_src2_hit (fwd_src2_hit),
    .fwd_src1_val (fwd_src1_val),
    .fwd_src2_val (fwd_src2_val),
    .exec_valid   (exec_valid),
    .exec_ready   (exec_ready),
    .exec_pkt     (exec_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PREG_W-1:0] s1, s2;
    logic [XLEN-1:0]   rf1, rf2;
    logic              hit1, hit2;
    logic [XLEN-1:0]   fw1, fw2;
    logic [XLEN-1:0]   exp1, exp2;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic sched_pkt_t mk_pkt(input logic [XLEN-1:0] pc,
                                        input logic [PREG_W-1:0] s1,
                                        input logic [PREG_W-1:0] s2,
                                        input logic [PREG_W-1:0] d,
                                        input logic [XLEN-1:0] imm);
    sched_pkt_t p;
    p.pc = pc; p.src1_preg = s1; p.src2_preg = s2; p.dst_preg = d;
    p.imm_val = imm; p.instr_valid = 1'b1;
    return p;
  endfunction

  initial begin
    vecs[0] = '{s1:6'd5,  s2:6'd10, rf1:32'hAAAA_AAAA, rf2:32'hBBBB_BBBB, hit1:1'b1, hit2:1'b0,
                fw1:32'hDEAD_BEEF, fw2:32'h0, exp1:32'hDEAD_BEEF, exp2:32'hBBBB_BBBB};
    vecs[1] = '{s1:6'd0,  s2:6'd0,  rf1:32'h5555_5555, rf2:32'h5555_5555, hit1:1'b1, hit2:1'b1,
                fw1:32'h1234_5678, fw2:32'h1234_5678, exp1:32'h0, exp2:32'h0};
    vecs[2] = '{s1:6'd3,  s2:6'd4,  rf1:32'h1111_1111, rf2:32'h2222_2222, hit1:1'b0, hit2:1'b0,
                fw1:32'h9999_9999, fw2:32'h8888_8888, exp1:32'h1111_1111, exp2:32'h2222_2222};
    vecs[3] = '{s1:6'd7,  s2:6'd0,  rf1:32'h0000_0077, rf2:32'h0000_0066, hit1:1'b1, hit2:1'b1,
                fw1:32'hCAFE_F00D, fw2:32'h0000_0099, exp1:32'hCAFE_F00D, exp2:32'h0};
    vecs[4] = '{s1:6'd63, s2:6'd1,  rf1:32'hFFFF_FFFF, rf2:32'h0000_0001, hit1:1'b0, hit2:1'b1,
                fw1:32'h0, fw2:32'h0000_ABCD, exp1:32'hFFFF_FFFF, exp2:32'h0000_ABCD};

    rst = 1'b0; flush = 1'b0; sched_valid = '0; sched_pkt = '0;
    rf_src1_val = '0; rf_src2_val = '0; fwd_src1_hit = '0; fwd_src2_hit = '0;
    fwd_src1_val = '0; fwd_src2_val = '0; exec_ready = '1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_exec_valid", exec_valid, 2'b00);
    check("rst_pkt_zero", |exec_pkt, 1'b0);
    check("rst_sched_ready", sched_ready, 2'b11);
    rst = 1'b1;
    tick();
    tick();
    check("idle_exec_valid", exec_valid, 2'b00);
    check("idle_sched_ready", sched_ready, 2'b11);

    // Operand-select table, streamed back-to-back on lane 0.
    for (int i = 0; i < 5; i++) begin
      sched_valid[0]  = 1'b1;
      sched_pkt[0]    = mk_pkt(32'h1000 + 32'(i) * 4, vecs[i].s1, vecs[i].s2,
                               6'(20 + i), 32'h100 + 32'(i));
      rf_src1_val[0]  = vecs[i].rf1;  rf_src2_val[0]  = vecs[i].rf2;
      fwd_src1_hit[0] = vecs[i].hit1; fwd_src2_hit[0] = vecs[i].hit2;
      fwd_src1_val[0] = vecs[i].fw1;  fwd_src2_val[0] = vecs[i].fw2;
      #1;
      check($sformatf("v%0d_rf_src1_reg", i), rf_src1_reg[0], vecs[i].s1);
      check($sformatf("v%0d_fwd_src2_reg", i), fwd_src2_reg[0], vecs[i].s2);
      tick();
      check($sformatf("v%0d_exec_valid", i), exec_valid[0], 1'b1);
      check($sformatf("v%0d_pc", i), exec_pkt[0].pc, 32'h1000 + 32'(i) * 4);
      check($sformatf("v%0d_src1_val", i), exec_pkt[0].src1_val, vecs[i].exp1);
      check($sformatf("v%0d_src2_val", i), exec_pkt[0].src2_val, vecs[i].exp2);
      check($sformatf("v%0d_dst", i), exec_pkt[0].dst_preg, 6'(20 + i));
      check($sformatf("v%0d_imm", i), exec_pkt[0].imm_val, 32'h100 + 32'(i));
      check($sformatf("v%0d_sched_ready", i), sched_ready, 2'b11);
    end
    sched_valid = '0;
    fwd_src1_hit = '0; fwd_src2_hit = '0;
    tick();
    check("stream_drained", exec_valid, 2'b00);

    // Lane 1 stalled, lane 0 streaming.
    exec_ready = 2'b01;
    sched_valid = 2'b11;
    sched_pkt[1] = mk_pkt(32'h2000, 6'd1, 6'd2, 6'd3, 32'h0);
    sched_pkt[0] = mk_pkt(32'h3000, 6'd1, 6'd2, 6'd3, 32'h0);
    tick();
    check("skid_a_l1_pc", exec_pkt[1].pc, 32'h2000);
    check("skid_a_l1_ready", sched_ready[1], 1'b1);
    check("skid_a_l0_pc", exec_pkt[0].pc, 32'h3000);
    sched_pkt[1] = mk_pkt(32'h2004, 6'd1, 6'd2, 6'd3, 32'h0);
    sched_pkt[0] = mk_pkt(32'h3004, 6'd1, 6'd2, 6'd3, 32'h0);
    tick();
    check("skid_b_l1_ready", sched_ready[1], 1'b0);
    check("skid_b_l1_pc", exec_pkt[1].pc, 32'h2000);
    check("skid_b_l0_pc", exec_pkt[0].pc, 32'h3004);
    check("skid_b_l0_ready", sched_ready[0], 1'b1);
    // Scheduler keeps valid high while lane 1 is not ready; must not be taken.
    sched_pkt[1] = mk_pkt(32'h2008, 6'd1, 6'd2, 6'd3, 32'h0);
    sched_pkt[0] = mk_pkt(32'h3008, 6'd1, 6'd2, 6'd3, 32'h0);
    tick();
    check("skid_c_l1_pc", exec_pkt[1].pc, 32'h2000);
    check("skid_c_l1_ready", sched_ready[1], 1'b0);
    check("skid_c_l0_pc", exec_pkt[0].pc, 32'h3008);
    sched_valid = 2'b00;
    exec_ready = 2'b11;
    tick();
    check("skid_d_l1_pc", exec_pkt[1].pc, 32'h2004);
    check("skid_d_l1_valid", exec_valid[1], 1'b1);
    check("skid_d_l1_ready", sched_ready[1], 1'b1);
    check("skid_d_l0_valid", exec_valid[0], 1'b0);
    tick();
    check("skid_e_valid", exec_valid, 2'b00);

    // Flush: lane 0 OUT+SKID full, lane 1 OUT only, new packets arriving.
    exec_ready = 2'b00;
    sched_valid = 2'b11;
    sched_pkt[0] = mk_pkt(32'h4000, 6'd1, 6'd2, 6'd3, 32'h0);
    sched_pkt[1] = mk_pkt(32'h5000, 6'd1, 6'd2, 6'd3, 32'h0);
    tick();
    sched_valid = 2'b01;
    sched_pkt[0] = mk_pkt(32'h4004, 6'd1, 6'd2, 6'd3, 32'h0);
    tick();
    check("fl_pre_ready", sched_ready, 2'b10);
    check("fl_pre_valid", exec_valid, 2'b11);
    flush = 1'b1;
    exec_ready = 2'b11;
    sched_valid = 2'b11;
    sched_pkt[0] = mk_pkt(32'h6000, 6'd1, 6'd2, 6'd3, 32'h0);
    sched_pkt[1] = mk_pkt(32'h6004, 6'd1, 6'd2, 6'd3, 32'h0);
    tick();
    check("fl_valid", exec_valid, 2'b00);
    check("fl_ready", sched_ready, 2'b11);
    flush = 1'b0;
    sched_valid = 2'b00;
    tick();
    check("fl_dropped", exec_valid, 2'b00);

    // Async reset mid-cycle while lane 0 is stalled with SKID full.
    exec_ready = 2'b00;
    sched_valid = 2'b01;
    sched_pkt[0] = mk_pkt(32'h7000, 6'd1, 6'd2, 6'd3, 32'h0);
    tick();
    sched_pkt[0] = mk_pkt(32'h7004, 6'd1, 6'd2, 6'd3, 32'h0);
    tick();
    sched_valid = 2'b00;
    check("ar_pre_ready", sched_ready[0], 1'b0);
    check("ar_pre_pc", exec_pkt[0].pc, 32'h7000);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", exec_valid, 2'b00);
    check("ar_pkt_zero", |exec_pkt, 1'b0);
    check("ar_ready", sched_ready, 2'b11);
    tick();
    rst = 1'b1;
    exec_ready = 2'b11;
    tick();
    check("ar_after_valid", exec_valid, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
